// File: rtl/ann_gpio_responder.sv
// Chip-side end of the 11-bit GPIO host protocol: two show-ahead FIFOs between
// host and ANN core, plus the IDLE/LOAD/RUN/SEND mode sequencer.

module ann_gpio_fifo #(
   parameter int unsigned WIDTH = 11,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             not_full,
   output logic             not_empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             ovf;
   logic             pop_ok;
   logic             push_ok;
   logic             drop;

   // A pop on an empty FIFO is ignored; a push on a full FIFO only lands if a pop frees the slot.
   assign pop_ok  = pop && (count != '0);
   assign push_ok = push && ((count != FULL_CNT) || pop_ok);
   assign drop    = push && !push_ok;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         ovf <= ovf | drop;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wdata;
   end

   assign not_full  = (count != FULL_CNT);
   assign not_empty = (count != '0);
   assign rdata     = not_empty ? mem[rd_ptr] : '0;

endmodule

module ann_gpio_responder #(
   parameter int unsigned DATA_WIDTH = 11,
   parameter int unsigned IN_DEPTH   = 8,
   parameter int unsigned OUT_DEPTH  = 8
) (
   input  logic                  io_clk,
   input  logic                  io_rst,
   input  logic                  in_fifo_wenq,
   input  logic [DATA_WIDTH-1:0] in_fifo_wdata,
   output logic                  in_fifo_wfull_n,
   input  logic                  out_fifo_deq,
   output logic [DATA_WIDTH-1:0] out_fifo_rdata,
   output logic                  out_fifo_rempty_n,
   input  logic                  fsm_start,
   input  logic                  load_kdtree,
   input  logic                  send_best_arr,
   output logic                  fsm_done,
   output logic [1:0]            core_mode,
   output logic                  core_start,
   input  logic                  core_done,
   output logic                  core_in_valid,
   output logic [DATA_WIDTH-1:0] core_in_data,
   input  logic                  core_in_ready,
   input  logic                  core_out_valid,
   input  logic [DATA_WIDTH-1:0] core_out_data,
   output logic                  core_out_ready
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_SEND = 2'd3
   } state_t;

   state_t state;
   state_t state_next;
   logic   start_q;
   logic   start_edge;
   logic   start_accept;
   logic   done_set;

   ann_gpio_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (IN_DEPTH)
   ) u_in_fifo (
      .clk       (io_clk),
      .rst       (io_rst),
      .push      (in_fifo_wenq),
      .wdata     (in_fifo_wdata),
      .pop       (core_in_ready),
      .rdata     (core_in_data),
      .not_full  (in_fifo_wfull_n),
      .not_empty (core_in_valid)
   );

   ann_gpio_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (OUT_DEPTH)
   ) u_out_fifo (
      .clk       (io_clk),
      .rst       (io_rst),
      .push      (core_out_valid && core_out_ready),
      .wdata     (core_out_data),
      .pop       (out_fifo_deq),
      .rdata     (out_fifo_rdata),
      .not_full  (core_out_ready),
      .not_empty (out_fifo_rempty_n)
   );

   assign start_edge = fsm_start && !start_q;
   assign core_mode  = state;

   always_ff @(posedge io_clk or posedge io_rst) begin
      if (io_rst) begin
         state      <= ST_IDLE;
         start_q    <= 1'b0;
         core_start <= 1'b0;
         fsm_done   <= 1'b0;
      end else begin
         state      <= state_next;
         start_q    <= fsm_start;
         core_start <= start_accept;
         if (start_accept)  fsm_done <= 1'b0;
         else if (done_set) fsm_done <= 1'b1;
      end
   end

   // In IDLE the host requests are prioritised load > start > send.
   always_comb begin
      state_next   = state;
      start_accept = 1'b0;
      done_set     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (load_kdtree) begin
               state_next = ST_LOAD;
            end else if (start_edge) begin
               state_next   = ST_RUN;
               start_accept = 1'b1;
            end else if (send_best_arr) begin
               state_next = ST_SEND;
            end
         end
         ST_LOAD: begin
            if (!load_kdtree && !core_in_valid) state_next = ST_IDLE;
         end
         ST_RUN: begin
            if (core_done) begin
               state_next = ST_IDLE;
               done_set   = 1'b1;
            end
         end
         ST_SEND: begin
            if (!send_best_arr) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_ann_gpio_responder.sv
// Scoreboarded bench for ann_gpio_responder: host/core stimulus with queued
// expectations for both FIFO paths and direct checks on the mode sequencer.

module tb_ann_gpio_responder;

   logic        io_clk = 1'b0;
   logic        io_rst;
   logic        in_fifo_wenq;
   logic [10:0] in_fifo_wdata;
   logic        in_fifo_wfull_n;
   logic        out_fifo_deq;
   logic [10:0] out_fifo_rdata;
   logic        out_fifo_rempty_n;
   logic        fsm_start;
   logic        load_kdtree;
   logic        send_best_arr;
   logic        fsm_done;
   logic [1:0]  core_mode;
   logic        core_start;
   logic        core_done;
   logic        core_in_valid;
   logic [10:0] core_in_data;
   logic        core_in_ready;
   logic        core_out_valid;
   logic [10:0] core_out_data;
   logic        core_out_ready;

   int unsigned checks   = 0;
   int unsigned failures = 0;
   int unsigned pulses   = 0;
   logic [10:0] in_q[$];
   logic [10:0] out_q[$];

   always #5 io_clk = ~io_clk;

   ann_gpio_responder #(
      .DATA_WIDTH (11),
      .IN_DEPTH   (8),
      .OUT_DEPTH  (8)
   ) dut (
      .io_clk            (io_clk),
      .io_rst            (io_rst),
      .in_fifo_wenq      (in_fifo_wenq),
      .in_fifo_wdata     (in_fifo_wdata),
      .in_fifo_wfull_n   (in_fifo_wfull_n),
      .out_fifo_deq      (out_fifo_deq),
      .out_fifo_rdata    (out_fifo_rdata),
      .out_fifo_rempty_n (out_fifo_rempty_n),
      .fsm_start         (fsm_start),
      .load_kdtree       (load_kdtree),
      .send_best_arr     (send_best_arr),
      .fsm_done          (fsm_done),
      .core_mode         (core_mode),
      .core_start        (core_start),
      .core_done         (core_done),
      .core_in_valid     (core_in_valid),
      .core_in_data      (core_in_data),
      .core_in_ready     (core_in_ready),
      .core_out_valid    (core_out_valid),
      .core_out_data     (core_out_data),
      .core_out_ready    (core_out_ready)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge io_clk);
      #1;
   endtask

   // Handshakes are sampled mid-cycle; they complete on the following rising edge.
   always @(negedge io_clk) begin
      if (!io_rst) begin
         if (core_in_valid && core_in_ready) begin
            check_eq("in_q_nonempty", in_q.size(), (in_q.size() != 0) ? in_q.size() : 1);
            if (in_q.size() != 0) check_eq("core_in_data", core_in_data, in_q.pop_front());
         end
         if (out_fifo_deq && out_fifo_rempty_n) begin
            check_eq("out_q_nonempty", out_q.size(), (out_q.size() != 0) ? out_q.size() : 1);
            if (out_q.size() != 0) check_eq("out_rdata", out_fifo_rdata, out_q.pop_front());
         end
         if (core_start) pulses++;
      end
   end

   initial begin
      io_rst = 1'b1;
      in_fifo_wenq = 1'b0;  in_fifo_wdata = '0;  out_fifo_deq = 1'b0;
      fsm_start = 1'b0;     load_kdtree = 1'b0;  send_best_arr = 1'b0;
      core_done = 1'b0;     core_in_ready = 1'b0;
      core_out_valid = 1'b0; core_out_data = '0;

      // Reset values
      repeat (5) @(posedge io_clk);
      #1;
      check_eq("rst_wfull_n",   in_fifo_wfull_n,   1);
      check_eq("rst_rempty_n",  out_fifo_rempty_n, 0);
      check_eq("rst_rdata",     out_fifo_rdata,    0);
      check_eq("rst_fsm_done",  fsm_done,          0);
      check_eq("rst_mode",      core_mode,         0);
      check_eq("rst_start",     core_start,        0);
      check_eq("rst_in_valid",  core_in_valid,     0);
      check_eq("rst_out_ready", core_out_ready,    1);
      io_rst = 1'b0;
      tick();

      // core_done outside RUN is ignored
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
      check_eq("done_idle_ignored", fsm_done, 0);
      check_eq("done_idle_mode", core_mode, 0);

      // LOAD streaming with core consuming every cycle
      begin
         logic [10:0] words [3] = '{11'h7FF, 11'h001, 11'h400};
         load_kdtree = 1'b1;
         core_in_ready = 1'b1;
         for (int i = 0; i < 3; i++) begin
            in_fifo_wenq = 1'b1;
            in_fifo_wdata = words[i];
            in_q.push_back(words[i]);
            tick();
            check_eq("load_in_valid", core_in_valid, 1);
            check_eq("load_in_data", core_in_data, words[i]);
            check_eq("load_wfull_n", in_fifo_wfull_n, 1);
         end
         in_fifo_wenq = 1'b0;
         tick();
         check_eq("load_mode", core_mode, 1);
         check_eq("load_drained", core_in_valid, 0);
         load_kdtree = 1'b0;
         core_in_ready = 1'b0;
         tick();
         check_eq("load_exit_mode", core_mode, 0);
         check_eq("load_q_empty", in_q.size(), 0);
      end

      // Input FIFO overflow: 9th word dropped
      for (int i = 0; i < 9; i++) begin
         in_fifo_wenq = 1'b1;
         in_fifo_wdata = 11'(11'h100 + i);
         if (in_q.size() < 8) in_q.push_back(11'(11'h100 + i));
         tick();
         check_eq("full_wfull_n", in_fifo_wfull_n, (i >= 7) ? 0 : 1);
      end
      in_fifo_wenq = 1'b0;
      core_in_ready = 1'b1;
      repeat (10) tick();
      core_in_ready = 1'b0;
      check_eq("full_drain_q", in_q.size(), 0);
      check_eq("full_drain_valid", core_in_valid, 0);

      // Search sequencing
      fsm_start = 1'b1;
      tick();
      check_eq("run_start_pulse", core_start, 1);
      check_eq("run_mode", core_mode, 2);
      tick();
      check_eq("run_start_once", core_start, 0);
      repeat (19) tick();
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
      check_eq("run_done_flag", fsm_done, 1);
      check_eq("run_done_mode", core_mode, 0);
      tick();
      check_eq("run_done_sticky", fsm_done, 1);
      check_eq("run_held_pulses", pulses, 1);
      fsm_start = 1'b0;
      load_kdtree = 1'b1;
      tick();
      check_eq("load2_mode", core_mode, 1);
      fsm_start = 1'b1;
      tick();
      check_eq("load2_no_pulse", core_start, 0);
      check_eq("load2_stay", core_mode, 1);
      load_kdtree = 1'b0;
      tick();
      check_eq("load2_exit", core_mode, 0);
      fsm_start = 1'b0;
      tick();
      fsm_start = 1'b1;
      tick();
      check_eq("run2_pulse", core_start, 1);
      check_eq("run2_done_clear", fsm_done, 0);
      check_eq("run2_mode", core_mode, 2);
      fsm_start = 1'b0;
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
      check_eq("run2_done", fsm_done, 1);
      check_eq("run2_pulses", pulses, 2);

      // SEND readback
      send_best_arr = 1'b1;
      tick();
      check_eq("send_mode", core_mode, 3);
      core_out_valid = 1'b1;
      core_out_data = 11'h123;
      out_q.push_back(11'h123);
      tick();
      check_eq("send_latency_valid", out_fifo_rempty_n, 1);
      check_eq("send_latency_data", out_fifo_rdata, 11'h123);
      core_out_data = 11'h456;
      out_q.push_back(11'h456);
      tick();
      core_out_valid = 1'b0;
      out_fifo_deq = 1'b1;
      repeat (2) tick();
      check_eq("send_empty", out_fifo_rempty_n, 0);
      tick();
      check_eq("send_deq_empty_rdata", out_fifo_rdata, 0);
      check_eq("send_deq_empty_flag", out_fifo_rempty_n, 0);
      out_fifo_deq = 1'b0;
      for (int i = 0; i < 9; i++) begin
         core_out_valid = 1'b1;
         core_out_data = 11'(11'h200 + i);
         if (core_out_ready) out_q.push_back(11'(11'h200 + i));
         tick();
      end
      core_out_valid = 1'b0;
      check_eq("send_full_ready", core_out_ready, 0);
      check_eq("send_full_q", out_q.size(), 8);
      out_fifo_deq = 1'b1;
      repeat (9) tick();
      out_fifo_deq = 1'b0;
      check_eq("send_drain_q", out_q.size(), 0);
      send_best_arr = 1'b0;
      tick();
      check_eq("send_exit_mode", core_mode, 0);

      // Reset mid-transfer with both FIFOs holding 3 words
      for (int i = 0; i < 3; i++) begin
         in_fifo_wenq = 1'b1;
         in_fifo_wdata = 11'(11'h300 + i);
         core_out_valid = 1'b1;
         core_out_data = 11'(11'h310 + i);
         tick();
      end
      in_fifo_wenq = 1'b0;
      core_out_valid = 1'b0;
      send_best_arr = 1'b1;
      tick();
      check_eq("flush_pre_in", core_in_valid, 1);
      check_eq("flush_pre_out", out_fifo_rempty_n, 1);
      check_eq("flush_pre_mode", core_mode, 3);
      io_rst = 1'b1;
      send_best_arr = 1'b0;
      #1;
      check_eq("flush_async_in", core_in_valid, 0);
      check_eq("flush_async_out", out_fifo_rempty_n, 0);
      tick();
      check_eq("flush_in_valid", core_in_valid, 0);
      check_eq("flush_wfull_n", in_fifo_wfull_n, 1);
      check_eq("flush_rempty_n", out_fifo_rempty_n, 0);
      check_eq("flush_out_ready", core_out_ready, 1);
      check_eq("flush_mode", core_mode, 0);
      io_rst = 1'b0;
      tick();
      check_eq("flush_after_in", core_in_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
